// File: rtl/frame_gen.sv
// Frame generator: overhead/payload/parity column mux fed by a payload byte FIFO.
// Optional BIP-8 parity accumulator compiled in with `define FRAME_GEN_BIP_EN.
module frame_gen #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_pl_valid,
  input  logic [7:0]                   i_pl_data,
  output logic                         o_pl_ready,
  input  logic [1:0]                   i_row_cnt,
  input  logic [10:0]                  i_col_cnt,
  input  logic                         i_line_retrans_req,
  output logic                         o_valid,
  output logic [7:0]                   o_data,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [7:0]    mfas_q;
  logic [7:0]    bip_byte;
  logic [7:0]    head;
  logic [7:0]    oh_byte;
  logic          push, pop, par_emit, fifo_nempty;
  logic          is_oh, is_pl, is_par;

  assign fifo_nempty  = (level_q != '0);
  assign head         = mem[rd_ptr_q];
  assign o_fifo_level = level_q;
  // Held low in reset so upstream never sees a ready it cannot use.
  assign o_pl_ready   = i_rst_n && (level_q < LW'(FIFO_DEPTH));
  assign push         = i_pl_valid && o_pl_ready;

  assign is_oh  = (i_col_cnt < 11'd16);
  assign is_pl  = (i_col_cnt >= 11'd16) && (i_col_cnt <= 11'd1039);
  assign is_par = (i_col_cnt == 11'd1040);

  always_comb begin
    oh_byte = 8'h00;
    if (i_row_cnt == 2'd0) begin
      if (i_col_cnt <= 11'd2)      oh_byte = 8'hF6;
      else if (i_col_cnt <= 11'd5) oh_byte = 8'h28;
      else if (i_col_cnt == 11'd6) oh_byte = mfas_q;
    end
  end

  always_comb begin
    o_valid  = 1'b0;
    o_data   = 8'h00;
    pop      = 1'b0;
    par_emit = 1'b0;
    if (i_rst_n) begin
      if (is_oh) begin
        o_valid = !i_line_retrans_req;
        o_data  = oh_byte;
      end else if (is_pl) begin
        o_valid = fifo_nempty && !i_line_retrans_req;
        o_data  = fifo_nempty ? head : 8'h00;
        pop     = o_valid;
      end else if (is_par) begin
        o_valid  = !i_line_retrans_req;
        o_data   = bip_byte;
        par_emit = o_valid;
      end
    end
  end

  // Storage needs no reset: occupancy and pointers alone define the contents.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_pl_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      mfas_q   <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (par_emit && (i_row_cnt == 2'd3)) mfas_q <= mfas_q + 8'd1;
    end
  end

`ifdef FRAME_GEN_BIP_EN
  logic [7:0] bip_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      bip_q <= 8'h00;
    else if (par_emit) bip_q <= 8'h00;
    else if (pop)      bip_q <= bip_q ^ head;
  end

  assign bip_byte = bip_q;
`else
  assign bip_byte = 8'h00;
`endif

endmodule

// File: tb/tb_frame_gen.sv
// Directed self-checking bench for frame_gen (FIFO_DEPTH=8); parity expectations
// follow whether FRAME_GEN_BIP_EN is defined for the build.
module tb_frame_gen;

  logic        clk;
  logic        rst_n;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_ready;
  logic [1:0]  row;
  logic [10:0] col;
  logic        retrans;
  logic        valid;
  logic [7:0]  data;
  logic [3:0]  level;

  int total = 0;
  int bad   = 0;

  frame_gen #(.FIFO_DEPTH(8)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pl_valid         (pl_valid),
    .i_pl_data          (pl_data),
    .o_pl_ready         (pl_ready),
    .i_row_cnt          (row),
    .i_col_cnt          (col),
    .i_line_retrans_req (retrans),
    .o_valid            (valid),
    .o_data             (data),
    .o_fifo_level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] oh_exp [7];
    logic [7:0] bip_a, bip_b, exp_b;
    int errs;

    oh_exp = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28, 8'h00};
`ifdef FRAME_GEN_BIP_EN
    bip_a = 8'hF0;
    bip_b = 8'h02;
`else
    bip_a = 8'h00;
    bip_b = 8'h00;
`endif

    rst_n = 1'b0; pl_valid = 1'b1; pl_data = 8'h77; row = 2'd0; col = 11'd0; retrans = 1'b0;
    step(); step();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_ready", {31'd0, pl_ready}, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);

    pl_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, pl_ready}, 32'd1);
    chk("post_rst_level", {28'd0, level}, 32'd0);

    // Row 0 overhead bytes, MFAS reads 0
    for (int c = 0; c < 7; c++) begin
      col = 11'(c);
      #1;
      chk($sformatf("oh_valid_c%0d", c), {31'd0, valid}, 32'd1);
      chk($sformatf("oh_data_c%0d", c), {24'd0, data}, {24'd0, oh_exp[c]});
    end
    row = 2'd1; col = 11'd0; #1;
    chk("oh_row1_data", {24'd0, data}, 32'h00);
    row = 2'd0; col = 11'd3; retrans = 1'b1; #1;
    chk("oh_retrans_valid", {31'd0, valid}, 32'd0);
    retrans = 1'b0;

    col = 11'd1041; #1;
    chk("oor_valid", {31'd0, valid}, 32'd0);
    chk("oor_data", {24'd0, data}, 32'h00);
    col = 11'd2047; #1;
    chk("oor_max_valid", {31'd0, valid}, 32'd0);

    // Empty FIFO at payload column, then push with no bypass
    col = 11'd16; #1;
    chk("empty_pl_valid", {31'd0, valid}, 32'd0);
    pl_valid = 1'b1; pl_data = 8'hA5; #1;
    chk("no_bypass_valid", {31'd0, valid}, 32'd0);
    step();
    pl_valid = 1'b0; #1;
    chk("a5_valid", {31'd0, valid}, 32'd1);
    chk("a5_data", {24'd0, data}, 32'hA5);
    chk("a5_level", {28'd0, level}, 32'd1);
    step();
    chk("a5_popped_level", {28'd0, level}, 32'd0);
    chk("a5_popped_valid", {31'd0, valid}, 32'd0);

    // Fill with 10 pushes and no pops
    col = 11'd2000;
    for (int i = 0; i < 10; i++) begin
      pl_valid = 1'b1; pl_data = 8'(8'h10 + i); #1;
      chk($sformatf("fill_ready_%0d", i), {31'd0, pl_ready}, (i < 8) ? 32'd1 : 32'd0);
      step();
    end
    pl_valid = 1'b0; #1;
    chk("full_level", {28'd0, level}, 32'd8);
    chk("full_ready", {31'd0, pl_ready}, 32'd0);

    // Full: pop alone succeeds, push refused in the same cycle
    col = 11'd16; pl_valid = 1'b1; pl_data = 8'hEE; #1;
    chk("full_pop_data", {24'd0, data}, 32'h10);
    step();
    chk("full_pop_level", {28'd0, level}, 32'd7);

    // Simultaneous push and pop
    col = 11'd17; pl_valid = 1'b1; pl_data = 8'h55; #1;
    chk("pushpop_data", {24'd0, data}, 32'h11);
    step();
    pl_valid = 1'b0; #1;
    chk("pushpop_level", {28'd0, level}, 32'd7);

    for (int i = 0; i < 3; i++) begin
      col = 11'(18 + i); #1;
      chk($sformatf("pop_order_%0d", i), {24'd0, data}, {24'd0, 8'(8'h12 + i)});
      step();
    end
    chk("pre_retrans_level", {28'd0, level}, 32'd4);

    // Retransmit hold at column 500
    col = 11'd500; retrans = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (valid !== 1'b0) errs++;
      step();
    end
    chk("retrans_valid_errs", errs, 32'd0);
    chk("retrans_level", {28'd0, level}, 32'd4);
    retrans = 1'b0;

    exp_b = 8'h15;
    for (int i = 0; i < 4; i++) begin
      col = 11'(501 + i); #1;
      chk($sformatf("drain_%0d", i), {24'd0, data}, {24'd0, (i == 3) ? 8'h55 : 8'(exp_b + i)});
      step();
    end
    chk("drained_level", {28'd0, level}, 32'd0);

    // Parity on row 0: no MFAS bump
    col = 11'd1040; #1;
    chk("par0_valid", {31'd0, valid}, 32'd1);
    chk("par0_data", {24'd0, data}, {24'd0, bip_a});
    step();
    chk("par0_cleared", {24'd0, data}, 32'h00);
    col = 11'd6; #1;
    chk("mfas_still0", {24'd0, data}, 32'h00);

    // Row 3 stream: 1023 x 0x01 then 0x03
    row = 2'd3; col = 11'd2000; pl_valid = 1'b1; pl_data = 8'h01;
    step();
    errs = 0;
    for (int c = 16; c < 1040; c++) begin
      int k;
      k = c - 16;
      col = 11'(c);
      if (k + 1 < 1024) begin
        pl_valid = 1'b1;
        pl_data = (k + 1 == 1023) ? 8'h03 : 8'h01;
      end else begin
        pl_valid = 1'b0;
      end
      #1;
      if (valid !== 1'b1 || data !== ((k == 1023) ? 8'h03 : 8'h01)) errs++;
      step();
    end
    chk("stream_errs", errs, 32'd0);
    pl_valid = 1'b0; col = 11'd1040; #1;
    chk("par3_valid", {31'd0, valid}, 32'd1);
    chk("par3_data", {24'd0, data}, {24'd0, bip_b});
    chk("par3_level", {28'd0, level}, 32'd0);
    step();

    row = 2'd0; col = 11'd6; #1;
    chk("mfas_1", {24'd0, data}, 32'h01);

    row = 2'd3; col = 11'd1040; retrans = 1'b1;
    step();
    retrans = 1'b0; row = 2'd0; col = 11'd6; #1;
    chk("mfas_retrans_hold", {24'd0, data}, 32'h01);

    // MFAS walk to 255 and wrap
    errs = 0;
    for (int m = 1; m < 256; m++) begin
      row = 2'd0; col = 11'd6; #1;
      if (data !== 8'(m)) errs++;
      row = 2'd3; col = 11'd1040;
      step();
    end
    chk("mfas_walk_errs", errs, 32'd0);
    row = 2'd0; col = 11'd6; #1;
    chk("mfas_wrap", {24'd0, data}, 32'h00);

    // Mid-frame reset discards FIFO, partial BIP and MFAS
    row = 2'd3; col = 11'd1040; step();
    col = 11'd2000; pl_valid = 1'b1; pl_data = 8'h3C;
    step(); step(); step();
    pl_valid = 1'b0; col = 11'd20;
    step();
    chk("pre_rst_level", {28'd0, level}, 32'd2);
    rst_n = 1'b0; #1;
    chk("midrst_level", {28'd0, level}, 32'd0);
    chk("midrst_ready", {31'd0, pl_ready}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    #1;
    chk("after_rst_pl_valid", {31'd0, valid}, 32'd0);
    col = 11'd1040; #1;
    chk("after_rst_bip", {24'd0, data}, 32'h00);
    row = 2'd0; col = 11'd6; #1;
    chk("after_rst_mfas", {24'd0, data}, 32'h00);
    chk("after_rst_ready", {31'd0, pl_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_gen.md
FRAME_GEN -- requirements
Module: frame_gen

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, payload FIFO entries; power of two, 4 to 64.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_pl_valid  input  1  upstream payload byte valid.
REQ-005 i_pl_data  input  8  upstream payload byte.
REQ-006 o_pl_ready  output  1  FIFO can accept a byte.
REQ-007 i_row_cnt  input  2  current frame row (0-3), from the frame position counter.
REQ-008 i_col_cnt  input  11  current frame column (0-1040), from the frame position counter.
REQ-009 i_line_retrans_req  input  1  line retransmit hold; the same signal the counter receives.
REQ-010 o_valid  output  1  o_data is a frame byte; drives the counter's i_valid.
REQ-011 o_data  output  8  frame byte for the position (i_row_cnt, i_col_cnt).
REQ-012 o_fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Columns: 0-15 overhead (OH), 16-1039 payload, 1040 parity; a frame is 4 rows.
REQ-014 o_valid and o_data shall be combinational from the position inputs, retransmit hold, FIFO state and registered state; there is no output register.
REQ-015 In OH and parity columns, o_valid shall be 1 unless i_line_retrans_req=1.
REQ-016 OH bytes: row 0 cols 0-2 = 0xF6; row 0 cols 3-5 = 0x28; row 0 col 6 = MFAS register; all other OH bytes = 0x00.
REQ-017 In payload columns, o_valid shall be (FIFO not empty) AND NOT i_line_retrans_req, and o_data shall be the FIFO head.
REQ-018 Pop shall occur exactly when o_valid=1 in a payload column.
REQ-019 The FIFO shall be first-in first-out with FIFO_DEPTH entries.
REQ-020 Push shall occur when i_pl_valid=1 and o_pl_ready=1.
REQ-021 o_pl_ready shall be 1 exactly when o_fifo_level < FIFO_DEPTH.
REQ-022 A byte pushed in cycle t shall not be poppable before cycle t+1, so an empty FIFO never bypasses.
REQ-023 Simultaneous push and pop shall leave o_fifo_level unchanged.
REQ-024 Pointers shall wrap modulo FIFO_DEPTH.
REQ-025 When o_fifo_level=FIFO_DEPTH, o_pl_ready shall be 0 and no push occurs, even if a pop happens that cycle.
REQ-026 MFAS register: 8 bits; it shall increment by 1 (wrapping 255->0) on the cycle row 3 col 1040 is emitted with o_valid=1.
REQ-027 While i_line_retrans_req=1: o_valid=0, no pop, no BIP or MFAS update; pushes continue normally.
REQ-028 Position values outside the defined range (col > 1040) shall give o_valid=0 and o_data=0x00.

Reset
REQ-029 While i_rst_n=0: FIFO empty, pointers 0, o_fifo_level=0, MFAS=0, BIP accumulator=0, o_valid=0, o_data=0x00, o_pl_ready=0.
REQ-030 After reset deasserts, o_pl_ready shall be 1 and all state shall restart from its reset values.
REQ-031 Reset asserted mid-frame shall discard FIFO contents and the partial BIP without emitting them.

Configuration
REQ-032 Macro FRAME_GEN_BIP_EN defined: the BIP-8 accumulator is compiled in.
REQ-033 With FRAME_GEN_BIP_EN, the accumulator XORs each popped payload byte of the row.
REQ-034 With FRAME_GEN_BIP_EN, col 1040 o_data = accumulator (XOR of that row's payload bytes), and the accumulator clears to 0 on that emit.
REQ-035 Macro FRAME_GEN_BIP_EN undefined: no accumulator logic, and col 1040 o_data = 0x00.

Verification
REQ-036 Reset, then row 0 cols 0-6 with retrans=0 -> o_valid=1; o_data F6,F6,F6,28,28,28,00.
REQ-037 FIFO_DEPTH=8, push 10 bytes with no pops -> 8 accepted; o_pl_ready=0 after the 8th; level=8.
REQ-038 Payload col 16 with FIFO empty -> o_valid=0; push 0xA5 -> o_valid=1 with o_data=0xA5 the next cycle.
REQ-039 BIP_EN, row payload 0x01 x1023 then 0x03 -> col 1040 o_data=0x02; without the macro -> 0x00.
REQ-040 i_line_retrans_req=1 for 5 cycles at col 500 with level 4 -> o_valid=0; level stays 4; BIP unchanged.
REQ-041 Run 256 full frames -> MFAS at row 0 col 6 counts 0..255 and then reads 0 again.
